pong_game_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 25 ++
 rtl/pong_ball_step.sv | 70 +++++++
 rtl/pong_game_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong state encoding, playfield geometry and screen centre
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    MISS     = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  // Playfield geometry in active-pixel space; the renderer draws from the same values.
  localparam int PF_FIELD_L   = 50;
  localparam int PF_FIELD_R   = 590;
  localparam int PF_FIELD_T   = 50;
  localparam int PF_FIELD_B   = 430;
  localparam int PF_BALL_HALF = 5;
  localparam int PF_PAD_X     = 55;
  localparam int PF_PAD_W     = 15;
  localparam int PF_PAD_H     = 100;

  localparam logic [9:0] CENTER_X = 10'd320;
  localparam logic [9:0] CENTER_Y = 10'd240;

endpackage

// File: rtl/pong_ball_step.sv
// rtl/pong_ball_step.sv - combinational one-frame ball advance with wall bounce, paddle hit and miss
module pong_ball_step
  import pong_pkg::*;
#(
  parameter int FIELD_L   = PF_FIELD_L,
  parameter int FIELD_R   = PF_FIELD_R,
  parameter int FIELD_T   = PF_FIELD_T,
  parameter int FIELD_B   = PF_FIELD_B,
  parameter int BALL_HALF = PF_BALL_HALF,
  parameter int PAD_X     = PF_PAD_X,
  parameter int PAD_W     = PF_PAD_W,
  parameter int PAD_H     = PF_PAD_H,
  parameter int BALL_STEP = 1
) (
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_dx_pos,
  input  logic       i_dy_pos,
  input  logic [9:0] i_pad_y,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_dx_pos,
  output logic       o_dy_pos,
  output logic       o_hit,
  output logic       o_miss
);

  // Limits are expressed on the ball centre so no subtraction can wrap.
  localparam logic [9:0] X_MIN = 10'(FIELD_L + BALL_HALF);
  localparam logic [9:0] X_MAX = 10'(FIELD_R - BALL_HALF);
  localparam logic [9:0] Y_MIN = 10'(FIELD_T + BALL_HALF);
  localparam logic [9:0] Y_MAX = 10'(FIELD_B - BALL_HALF);
  localparam logic [9:0] X_PAD = 10'(PAD_X + PAD_W + BALL_HALF);
  localparam logic [9:0] STEP  = 10'(BALL_STEP);
  localparam logic [9:0] PH    = 10'(PAD_H);

  logic [9:0] w_cx;
  logic [9:0] w_cy;
  logic       w_on_pad;

  assign w_cx     = i_dx_pos ? i_x + STEP : i_x - STEP;
  assign w_cy     = i_dy_pos ? i_y + STEP : i_y - STEP;
  assign w_on_pad = (i_y >= i_pad_y) && (i_y < i_pad_y + PH);

  always_comb begin
    o_x      = w_cx;
    o_y      = w_cy;
    o_dx_pos = i_dx_pos;
    o_dy_pos = i_dy_pos;
    o_hit    = 1'b0;
    if (w_cy <= Y_MIN) begin
      o_y      = Y_MIN;
      o_dy_pos = 1'b1;
    end else if (w_cy >= Y_MAX) begin
      o_y      = Y_MAX;
      o_dy_pos = 1'b0;
    end
    if (w_cx >= X_MAX) begin
      o_x      = X_MAX;
      o_dx_pos = 1'b0;
    end
    if (!i_dx_pos && (w_cx <= X_PAD) && w_on_pad) begin
      o_x      = X_PAD;
      o_dx_pos = 1'b1;
      o_hit    = 1'b1;
    end
    o_miss = !o_hit && (w_cx <= X_MIN);
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - frame-synchronous Pong sequencer: serve/play/miss FSM, paddle and ball registers
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int FIELD_L      = PF_FIELD_L,
  parameter int FIELD_R      = PF_FIELD_R,
  parameter int FIELD_T      = PF_FIELD_T,
  parameter int FIELD_B      = PF_FIELD_B,
  parameter int BALL_HALF    = PF_BALL_HALF,
  parameter int PAD_X        = PF_PAD_X,
  parameter int PAD_W        = PF_PAD_W,
  parameter int PAD_H        = PF_PAD_H,
  parameter int PAD_STEP     = 2,
  parameter int BALL_STEP    = 1,
  parameter int SERVE_FRAMES = 60,
  parameter int LIVES        = 3
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       frame_tick,
  input  logic       btn_start,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad_y,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic [2:0] state
);

  localparam int         CNT_W    = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [9:0] PAD_MID  = 10'((FIELD_T + FIELD_B - PAD_H) / 2);
  localparam logic [9:0] PAD_MIN  = 10'(FIELD_T);
  localparam logic [9:0] PAD_MAX  = 10'(FIELD_B - PAD_H);
  localparam logic [9:0] PSTEP    = 10'(PAD_STEP);
  localparam logic [1:0] LIVES_V  = 2'(LIVES);

  state_t           r_state, w_state_nxt;
  logic [9:0]       r_ball_x, r_ball_y, r_pad_y;
  logic             r_dx_pos, r_dy_pos;
  logic [3:0]       r_score;
  logic [1:0]       r_lives;
  logic [CNT_W-1:0] r_cnt;

  logic [9:0]       w_ball_x_nxt, w_ball_y_nxt, w_pad_nxt, w_pad_move;
  logic             w_dx_nxt, w_dy_nxt, w_to_serve;
  logic [3:0]       w_score_nxt;
  logic [1:0]       w_lives_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [9:0]       w_step_x, w_step_y;
  logic             w_step_dx, w_step_dy, w_step_hit, w_step_miss;

  always_comb begin
    w_pad_move = r_pad_y;
    if (btn_up && !btn_down)
      w_pad_move = (r_pad_y < PAD_MIN + PSTEP) ? PAD_MIN : r_pad_y - PSTEP;
    else if (btn_down && !btn_up)
      w_pad_move = (r_pad_y + PSTEP > PAD_MAX) ? PAD_MAX : r_pad_y + PSTEP;
  end

  // The ball sees the paddle position it is about to be drawn against.
  pong_ball_step #(
    .FIELD_L(FIELD_L), .FIELD_R(FIELD_R), .FIELD_T(FIELD_T), .FIELD_B(FIELD_B),
    .BALL_HALF(BALL_HALF), .PAD_X(PAD_X), .PAD_W(PAD_W), .PAD_H(PAD_H),
    .BALL_STEP(BALL_STEP)
  ) u_step (
    .i_x(r_ball_x), .i_y(r_ball_y), .i_dx_pos(r_dx_pos), .i_dy_pos(r_dy_pos),
    .i_pad_y(w_pad_move),
    .o_x(w_step_x), .o_y(w_step_y), .o_dx_pos(w_step_dx), .o_dy_pos(w_step_dy),
    .o_hit(w_step_hit), .o_miss(w_step_miss)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_ball_x_nxt = r_ball_x;
    w_ball_y_nxt = r_ball_y;
    w_dx_nxt     = r_dx_pos;
    w_dy_nxt     = r_dy_pos;
    w_pad_nxt    = r_pad_y;
    w_score_nxt  = r_score;
    w_lives_nxt  = r_lives;
    w_cnt_nxt    = r_cnt;
    w_to_serve   = 1'b0;
    if (frame_tick) begin
      case (r_state)
        IDLE: begin
          w_pad_nxt = PAD_MID;
          if (btn_start) begin
            w_lives_nxt = LIVES_V;
            w_score_nxt = '0;
            w_to_serve  = 1'b1;
          end
        end
        SERVE: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = PLAY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        PLAY: begin
          w_pad_nxt    = w_pad_move;
          w_ball_x_nxt = w_step_x;
          w_ball_y_nxt = w_step_y;
          w_dx_nxt     = w_step_dx;
          w_dy_nxt     = w_step_dy;
          if (w_step_hit && r_score != 4'hF) w_score_nxt = r_score + 4'd1;
          if (w_step_miss) w_state_nxt = MISS;
        end
        MISS: begin
          w_lives_nxt = (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;
          if (r_lives <= 2'd1) w_state_nxt = GAMEOVER;
          else                 w_to_serve  = 1'b1;
        end
        GAMEOVER: begin
          if (btn_start) begin
            w_state_nxt = IDLE;
            w_pad_nxt   = PAD_MID;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
      if (w_to_serve) begin
        w_state_nxt  = SERVE;
        w_ball_x_nxt = CENTER_X;
        w_ball_y_nxt = CENTER_Y;
        w_dx_nxt     = 1'b1;
        w_dy_nxt     = 1'b1;
        w_cnt_nxt    = '0;
      end
    end
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      r_state  <= IDLE;
      r_ball_x <= CENTER_X;
      r_ball_y <= CENTER_Y;
      r_dx_pos <= 1'b1;
      r_dy_pos <= 1'b1;
      r_pad_y  <= PAD_MID;
      r_score  <= '0;
      r_lives  <= LIVES_V;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ball_x <= w_ball_x_nxt;
      r_ball_y <= w_ball_y_nxt;
      r_dx_pos <= w_dx_nxt;
      r_dy_pos <= w_dy_nxt;
      r_pad_y  <= w_pad_nxt;
      r_score  <= w_score_nxt;
      r_lives  <= w_lives_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign ball_x = r_ball_x;
  assign ball_y = r_ball_y;
  assign pad_y  = r_pad_y;
  assign score  = r_score;
  assign lives  = r_lives;
  assign state  = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - scoreboard bench for pong_game_ctrl against a frame-level game model
module tb_pong_game_ctrl;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_MISS = 3, S_OVER = 4;

  logic       dclk = 1'b0;
  logic       clr = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_start = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [9:0] ball_x, ball_y, pad_y;
  logic [3:0] score;
  logic [1:0] lives;
  logic [2:0] state;

  pong_game_ctrl dut (
    .dclk(dclk), .clr(clr), .frame_tick(frame_tick),
    .btn_start(btn_start), .btn_up(btn_up), .btn_down(btn_down),
    .ball_x(ball_x), .ball_y(ball_y), .pad_y(pad_y),
    .score(score), .lives(lives), .state(state)
  );

  always #20 dclk = ~dclk;

  typedef struct packed {
    logic [2:0] st;
    logic [9:0] bx;
    logic [9:0] by;
    logic [9:0] pad;
    logic [3:0] sc;
    logic [1:0] lv;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int m_state, m_bx, m_by, m_pad, m_score, m_lives, m_cnt;
  bit m_dx, m_dy, m_hit;

  task automatic model_reset();
    m_state = S_IDLE; m_bx = 320; m_by = 240; m_pad = 190;
    m_score = 0; m_lives = 3; m_cnt = 0; m_dx = 1; m_dy = 1; m_hit = 0;
  endtask

  task automatic model_serve();
    m_state = S_SERVE; m_bx = 320; m_by = 240; m_dx = 1; m_dy = 1; m_cnt = 0;
  endtask

  task automatic model_tick(input bit up, input bit dn, input bit st);
    int nx, ny;
    bit ndx, ndy;
    m_hit = 0;
    case (m_state)
      S_IDLE: begin
        m_pad = 190;
        if (st) begin m_lives = 3; m_score = 0; model_serve(); end
      end
      S_SERVE: begin
        if (m_cnt == 59) begin m_state = S_PLAY; m_cnt = 0; end
        else m_cnt++;
      end
      S_PLAY: begin
        if (up && !dn)      m_pad = (m_pad - 2 < 50) ? 50 : m_pad - 2;
        else if (dn && !up) m_pad = (m_pad + 2 > 330) ? 330 : m_pad + 2;
        nx = m_dx ? m_bx + 1 : m_bx - 1;
        ny = m_dy ? m_by + 1 : m_by - 1;
        ndx = m_dx; ndy = m_dy;
        if (ny - 5 <= 50)       begin ny = 55;  ndy = 1; end
        else if (ny + 5 >= 430) begin ny = 425; ndy = 0; end
        if (nx + 5 >= 590) begin nx = 585; ndx = 0; end
        if (!m_dx && nx - 5 <= 70 && m_by >= m_pad && m_by < m_pad + 100) begin
          nx = 75; ndx = 1; m_hit = 1;
          if (m_score < 15) m_score++;
        end
        m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy;
        if (!m_hit && nx - 5 <= 50) m_state = S_MISS;
      end
      S_MISS: begin
        if (m_lives <= 1) m_state = S_OVER;
        else model_serve();
        if (m_lives > 0) m_lives--;
      end
      S_OVER: begin
        if (st) begin m_state = S_IDLE; m_pad = 190; end
      end
      default: m_state = S_IDLE;
    endcase
  endtask

  task automatic do_tick(input bit up, input bit dn, input bit st);
    exp_t e, got;
    @(negedge dclk);
    btn_up = up; btn_down = dn; btn_start = st; frame_tick = 1'b1;
    model_tick(up, dn, st);
    e.st = 3'(m_state); e.bx = 10'(m_bx); e.by = 10'(m_by);
    e.pad = 10'(m_pad); e.sc = 4'(m_score); e.lv = 2'(m_lives);
    sb_q.push_back(e);
    @(posedge dclk);
    #1;
    frame_tick = 1'b0;
    e = sb_q.pop_front();
    got = {state, ball_x, ball_y, pad_y, score, lives};
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL tick: got st=%0d x=%0d y=%0d pad=%0d sc=%0d lv=%0d, required st=%0d x=%0d y=%0d pad=%0d sc=%0d lv=%0d",
               got.st, got.bx, got.by, got.pad, got.sc, got.lv, e.st, e.bx, e.by, e.pad, e.sc, e.lv);
    end
  endtask

  task automatic track_tick(input bit chase);
    int want;
    if (chase) want = (m_by - 50 < 50) ? 50 : ((m_by - 50 > 330) ? 330 : m_by - 50);
    else       want = (m_by >= 240) ? 50 : 330;
    do_tick(m_pad > want + 1, m_pad < want - 1, 1'b0);
  endtask

  task automatic run_serve();
    for (int i = 0; i < 60; i++) do_tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    n_tests++;
    if ({state, ball_x, ball_y, pad_y, score, lives} !== {3'd0, 10'd320, 10'd240, 10'd190, 4'd0, 2'd3}) begin
      n_fail++;
      $display("FAIL %s: got st=%0d x=%0d y=%0d pad=%0d sc=%0d lv=%0d, required 0/320/240/190/0/3",
               tag, state, ball_x, ball_y, pad_y, score, lives);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (3) @(posedge dclk);
    #1 clr = 1'b0;
    model_reset();
    check_reset_values("reset");
  endtask

  task automatic test_serve();
    do_tick(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (state !== 3'd1 || lives !== 2'd3) begin
      n_fail++; $display("FAIL start: got st=%0d lv=%0d, required st=1 lv=3", state, lives);
    end
    for (int i = 0; i < 59; i++) do_tick(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (state !== 3'd1) begin n_fail++; $display("FAIL serve_hold: got st=%0d, required 1", state); end
    do_tick(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (state !== 3'd2) begin n_fail++; $display("FAIL serve_end: got st=%0d, required 2", state); end
  endtask

  task automatic test_play_step();
    do_tick(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (ball_x !== 10'd321 || ball_y !== 10'd241) begin
      n_fail++; $display("FAIL first_step: got (%0d,%0d), required (321,241)", ball_x, ball_y);
    end
  endtask

  task automatic test_wall();
    for (int i = 0; i < 300 && !(m_by == 424 && m_dy); i++) do_tick(1'b0, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (ball_y !== 10'd425) begin n_fail++; $display("FAIL wall_clamp: got y=%0d, required 425", ball_y); end
    do_tick(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (ball_y !== 10'd424) begin n_fail++; $display("FAIL wall_bounce: got y=%0d, required 424", ball_y); end
  endtask

  task automatic test_pad_buttons();
    do_tick(1'b1, 1'b1, 1'b0);
    n_tests++;
    if (pad_y !== 10'd190) begin n_fail++; $display("FAIL pad_both: got %0d, required 190", pad_y); end
    for (int i = 0; i < 80; i++) do_tick(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (pad_y !== 10'd50) begin n_fail++; $display("FAIL pad_top: got %0d, required 50", pad_y); end
    for (int i = 0; i < 150; i++) do_tick(1'b0, 1'b1, 1'b0);
    n_tests++;
    if (pad_y !== 10'd330) begin n_fail++; $display("FAIL pad_bottom: got %0d, required 330", pad_y); end
  endtask

  task automatic test_hit();
    bit seen = 0;
    for (int i = 0; i < 1500 && !seen; i++) begin track_tick(1'b1); seen = m_hit; end
    n_tests++;
    if (!seen || ball_x !== 10'd75 || score !== 4'd1) begin
      n_fail++; $display("FAIL hit: seen=%0d got x=%0d sc=%0d, required x=75 sc=1", seen, ball_x, score);
    end
  endtask

  task automatic test_score_sat();
    bit seen = 0;
    for (int i = 0; i < 16000 && m_score < 15; i++) track_tick(1'b1);
    for (int i = 0; i < 1200 && !seen; i++) begin track_tick(1'b1); seen = m_hit; end
    n_tests++;
    if (!seen || score !== 4'd15) begin
      n_fail++; $display("FAIL score_sat: seen=%0d got sc=%0d, required 15", seen, score);
    end
  endtask

  task automatic test_miss();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3000 && m_state != S_MISS; i++) track_tick(1'b0);
      n_tests++;
      if (state !== 3'd3) begin n_fail++; $display("FAIL miss_%0d: got st=%0d, required 3", k, state); end
      do_tick(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (lives !== 2'(2 - k) || state !== ((k < 2) ? 3'd1 : 3'd4)) begin
        n_fail++;
        $display("FAIL after_miss_%0d: got st=%0d lv=%0d, required st=%0d lv=%0d",
                 k, state, lives, (k < 2) ? 1 : 4, 2 - k);
      end
      if (k < 2) run_serve();
    end
    repeat (3) do_tick(1'b0, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b1);
    n_tests++;
    if (state !== 3'd0 || pad_y !== 10'd190) begin
      n_fail++; $display("FAIL restart: got st=%0d pad=%0d, required st=0 pad=190", state, pad_y);
    end
  endtask

  task automatic test_clr();
    do_tick(1'b0, 1'b0, 1'b1);
    run_serve();
    for (int i = 0; i < 5; i++) do_tick(1'b0, 1'b1, 1'b0);
    @(negedge dclk);
    clr = 1'b1;
    @(posedge dclk);
    #1;
    check_reset_values("clr_mid_play");
    clr = 1'b0;
    model_reset();
    do_tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_serve();
    test_play_step();
    test_wall();
    test_pad_buttons();
    test_hit();
    test_score_sat();
    test_miss();
    test_clr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_600_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

endmodule
